// File: rtl/main_mult3.sv
// 3x3 unsigned array multiplier with a registered operand stage and a registered product stage.
// Define MAIN_MULT3_PIPE_EN to add a register after the first adder row (latency 3 instead of 2).
module main_mult3 #(
   parameter logic [5:0] OUT_RST = 6'd0
) (
   input  logic clk,
   input  logic rst_n,
   output logic p0,
   output logic p1,
   output logic p2,
   output logic p3,
   output logic p4,
   output logic p5,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic b0,
   input  logic b1,
   input  logic b2,
   input  logic in_valid,
   output logic out_valid
);

   // Returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   logic [2:0] a_r;
   logic [2:0] b_r;
   logic       v1_r;
   logic [1:0] ha10_s;
   logic [1:0] fa11_s;
   logic [1:0] ha12_s;
   logic [4:0] row1_s;
   logic [2:0] pp2_s;
   logic [4:0] row1_q_s;
   logic [2:0] pp2_q_s;
   logic       v_q_s;
   logic [1:0] ha20_s;
   logic [1:0] fa21_s;
   logic [1:0] fa22_s;
   logic [5:0] prod_s;
   logic [5:0] p_r;
   logic       out_valid_r;

   // Operand capture stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r  <= 3'd0;
         b_r  <= 3'd0;
         v1_r <= 1'b0;
      end else begin
         a_r  <= {a2, a1, a0};
         b_r  <= {b2, b1, b0};
         v1_r <= in_valid;
      end
   end

   // First row folds the b1 partial products into the b0 row; row1_s holds product bits 0..4.
   assign ha10_s = half_add(a_r[1] & b_r[0], a_r[0] & b_r[1]);
   assign fa11_s = full_add(a_r[2] & b_r[0], a_r[1] & b_r[1], ha10_s[1]);
   assign ha12_s = half_add(a_r[2] & b_r[1], fa11_s[1]);
   assign row1_s = {ha12_s[1], ha12_s[0], fa11_s[0], ha10_s[0], a_r[0] & b_r[0]};
   assign pp2_s  = a_r & {3{b_r[2]}};

`ifdef MAIN_MULT3_PIPE_EN
   logic [4:0] row1_r;
   logic [2:0] pp2_r;
   logic       v2_r;

   // Mid-array register between the two adder rows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row1_r <= 5'd0;
         pp2_r  <= 3'd0;
         v2_r   <= 1'b0;
      end else begin
         row1_r <= row1_s;
         pp2_r  <= pp2_s;
         v2_r   <= v1_r;
      end
   end

   assign row1_q_s = row1_r;
   assign pp2_q_s  = pp2_r;
   assign v_q_s    = v2_r;
`else
   assign row1_q_s = row1_s;
   assign pp2_q_s  = pp2_s;
   assign v_q_s    = v1_r;
`endif

   assign ha20_s = half_add(row1_q_s[2], pp2_q_s[0]);
   assign fa21_s = full_add(row1_q_s[3], pp2_q_s[1], ha20_s[1]);
   assign fa22_s = full_add(row1_q_s[4], pp2_q_s[2], fa21_s[1]);
   assign prod_s = {fa22_s[1], fa22_s[0], fa21_s[0], ha20_s[0], row1_q_s[1:0]};

   // Product stage; an invalid slot leaves the last valid product in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_r         <= OUT_RST;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= v_q_s;
         if (v_q_s) begin
            p_r <= prod_s;
         end else begin
            p_r <= p_r;
         end
      end
   end

   assign p0        = p_r[0];
   assign p1        = p_r[1];
   assign p2        = p_r[2];
   assign p3        = p_r[3];
   assign p4        = p_r[4];
   assign p5        = p_r[5];
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_main_mult3.sv
// Randomized and directed bench for main_mult3 against a queue-based delay-line reference model.
// Honors MAIN_MULT3_PIPE_EN for the expected latency.
module tb_main_mult3;

`ifdef MAIN_MULT3_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a0, a1, a2, b0, b1, b2, in_valid;
   logic p0, p1, p2, p3, p4, p5, out_valid;
   logic [5:0] p_s;

   typedef struct packed {
      logic       v;
      logic [5:0] p;
   } slot_t;

   slot_t      q[$];
   logic [5:0] exp_p;
   logic       exp_v;
   int         n_chk;
   int         n_pass;
   bit         saw25;

   logic [2:0] sa [15] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd3, 3'd3, 3'd7, 3'd7, 3'd6, 3'd6, 3'd1, 3'd0};
   logic [2:0] sb [15] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd1, 3'd0};
   int         ep [15] = '{0, 0, 1, 2, 4, 8, 20, 15, 21, 49, 49, 42, 36, 1, 0};

   main_mult3 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p0        (p0),
      .p1        (p1),
      .p2        (p2),
      .p3        (p3),
      .p4        (p4),
      .p5        (p5),
      .a0        (a0),
      .a1        (a1),
      .a2        (a2),
      .b0        (b0),
      .b1        (b1),
      .b2        (b2),
      .in_valid  (in_valid),
      .out_valid (out_valid)
   );

   assign p_s = {p5, p4, p3, p2, p1, p0};

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_p = 6'd0;
      exp_v = 1'b0;
   endtask

   task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic v);
      {a2, a1, a0} = a;
      {b2, b1, b0} = b;
      in_valid     = v;
   endtask

   // Junk operands mid-cycle, then the real pair, one edge, then compare against the model.
   task automatic step(input logic [2:0] a, input logic [2:0] b, input logic v, input string tag);
      slot_t s;
      slot_t h;
      drive(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
      #2;
      drive(a, b, v);
      @(posedge clk);
      if (rst_n) begin
         s.v = v;
         s.p = 6'(int'(a) * int'(b));
         q.push_back(s);
         if (q.size() >= LAT) begin
            h     = q.pop_front();
            exp_v = h.v;
            if (h.v) exp_p = h.p;
         end else begin
            exp_v = 1'b0;
         end
      end
      #1;
      check({tag, "_p"}, int'(p_s), int'(exp_p));
      check({tag, "_v"}, int'(out_valid), int'(exp_v));
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      saw25  = 1'b0;
      model_reset();
      drive(3'd7, 3'd7, 1'b1);
      #1;
      check("rst_t0_p", int'(p_s), 0);
      check("rst_t0_v", int'(out_valid), 0);
      repeat (4) step(3'd7, 3'd7, 1'b1, "rst_hold");
      rst_n = 1'b1;

      for (int i = 0; i < 15 + LAT - 1; i++) begin
         if (i < 15) step(sa[i], sb[i], 1'b1, "seq");
         else        step(3'd0, 3'd0, 1'b0, "seq_flush");
         if (i >= LAT - 1) check("seq_tab", int'(p_s), ep[i - LAT + 1]);
      end

      step(3'd7, 3'd7, 1'b1, "hold_in");
      repeat (LAT + 2) step(3'd3, 3'd3, 1'b0, "hold");
      check("hold_p49", int'(p_s), 49);
      check("hold_v0", int'(out_valid), 0);

      step(3'd5, 3'd5, 1'b1, "fl_in");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("fl_rst_p", int'(p_s), 0);
      check("fl_rst_v", int'(out_valid), 0);
      repeat (2) step(3'd5, 3'd5, 1'b1, "fl_rst");
      rst_n = 1'b1;
      repeat (LAT + 2) begin
         step(3'd0, 3'd0, 1'b0, "fl_post");
         if (p_s == 6'd25) saw25 = 1'b1;
      end
      check("fl_no25", int'(saw25), 0);

      for (int ia = 0; ia < 8; ia++) begin
         for (int ib = 0; ib < 8; ib++) begin
            step(3'(ia), 3'(ib), 1'b1, "sweep");
         end
      end
      repeat (LAT) step(3'd0, 3'd0, 1'b0, "sweep_flush");

      repeat (300) step(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                        1'($urandom_range(3, 0) != 0), "rnd");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
